// File: rtl/video_pll_ctrl.sv
// Video PLL bring-up and supervision: reset pulsing, lock qualification with retry/fail,
// lock-loss recovery and dynamic phase-step bursts, all in the PLL reference clock domain.
module video_pll_ctrl #(
    parameter int RST_PULSE    = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 3,
    parameter int PHASE_GAP    = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_lock_i,
    input  logic       start_i,
    input  logic       phase_req_i,
    input  logic [2:0] phase_sel_i,
    input  logic       phase_dir_i,
    input  logic [7:0] phase_steps_i,
    output logic       pll_rst_o,
    output logic [2:0] phase_sel_o,
    output logic       phase_dir_o,
    output logic       phase_step_n_o,
    output logic       ready_o,
    output logic       video_rst_o,
    output logic       phase_busy_o,
    output logic       phase_done_o,
    output logic       lock_lost_o,
    output logic       fail_o,
    output logic [3:0] retry_cnt_o
);

    localparam int MAX_AB = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
    localparam int MAX_CD = (LOCK_STABLE > PHASE_GAP) ? LOCK_STABLE : PHASE_GAP;
    localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAXP + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXP);

    typedef enum logic [2:0] {
        S_RST_PLL, S_WAIT_LOCK, S_STABLE, S_RUN, S_PH_STEP, S_PH_GAP, S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       rem_q, rem_d;
    logic [2:0]       sel_q, sel_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             lost_q, lost_d;
    logic             pll_rst_q, step_n_q, busy_q, ready_q, fail_q;
    logic             restart;
    logic             lock_s;
    logic             clk_ok;

    assign lock_s = sync_q[1];
    assign clk_ok = (state_q == S_RUN) || (state_q == S_PH_STEP) || (state_q == S_PH_GAP);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        rem_d   = rem_q;
        sel_d   = sel_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        lost_d  = 1'b0;
        restart = 1'b0;
        if (start_i) begin
            state_d = S_RST_PLL;
            retry_d = '0;
            restart = 1'b1;
        end else if (clk_ok && !lock_s) begin
            // A lock drop abandons any burst in flight; phase_done is deliberately not raised.
            state_d = S_RST_PLL;
            lost_d  = 1'b1;
        end else begin
            case (state_q)
                S_RST_PLL:
                    if (cnt_q == CNT_W'(RST_PULSE - 1)) state_d = S_WAIT_LOCK;
                S_WAIT_LOCK:
                    if (lock_s) begin
                        state_d = S_STABLE;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        retry_d = retry_q + 4'd1;
                        state_d = (retry_d == 4'(MAX_RETRY)) ? S_FAIL : S_RST_PLL;
                    end
                S_STABLE:
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE - 1)) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end
                S_RUN:
                    if (phase_req_i) begin
                        if (phase_steps_i == 8'd0) begin
                            done_d = 1'b1;
                        end else begin
                            sel_d   = phase_sel_i;
                            dir_d   = phase_dir_i;
                            rem_d   = phase_steps_i;
                            state_d = S_PH_STEP;
                        end
                    end
                S_PH_STEP: begin
                    rem_d   = rem_q - 8'd1;
                    state_d = S_PH_GAP;
                end
                S_PH_GAP:
                    if (cnt_q == CNT_W'(PHASE_GAP - 1)) begin
                        if (rem_q != 8'd0) begin
                            state_d = S_PH_STEP;
                        end else begin
                            state_d = S_RUN;
                            done_d  = 1'b1;
                        end
                    end
                S_FAIL: state_d = S_FAIL;
                default: state_d = S_RST_PLL;
            endcase
        end
        // Shared counter restarts on every state entry and saturates rather than wrapping.
        if (restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_RST_PLL;
            cnt_q     <= '0;
            sync_q    <= '0;
            retry_q   <= '0;
            rem_q     <= '0;
            sel_q     <= '0;
            dir_q     <= 1'b0;
            done_q    <= 1'b0;
            lost_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            step_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= {sync_q[0], pll_lock_i};
            retry_q   <= retry_d;
            rem_q     <= rem_d;
            sel_q     <= sel_d;
            dir_q     <= dir_d;
            done_q    <= done_d;
            lost_q    <= lost_d;
            pll_rst_q <= (state_d == S_RST_PLL) || (state_d == S_FAIL);
            step_n_q  <= (state_d != S_PH_STEP);
            busy_q    <= (state_d == S_PH_STEP) || (state_d == S_PH_GAP);
            ready_q   <= (state_d == S_RUN) || (state_d == S_PH_STEP) || (state_d == S_PH_GAP);
            fail_q    <= (state_d == S_FAIL);
        end
    end

    assign pll_rst_o      = pll_rst_q;
    assign phase_sel_o    = sel_q;
    assign phase_dir_o    = dir_q;
    assign phase_step_n_o = step_n_q;
    assign ready_o        = ready_q;
    assign video_rst_o    = !ready_q;
    assign phase_busy_o   = busy_q;
    assign phase_done_o   = done_q;
    assign lock_lost_o    = lost_q;
    assign fail_o         = fail_q;
    assign retry_cnt_o    = retry_q;

endmodule

// File: tb/tb_video_pll_ctrl.sv
// Bench for video_pll_ctrl: directed sequences, a phase-burst vector table and random traffic,
// all shadowed every cycle by a behavioural model of the controller.
module tb_video_pll_ctrl;

    localparam int RP = 4, LT = 20, LS = 8, PG = 2, MR = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, pll_lock = 1'b0, start = 1'b0, phase_req = 1'b0;
    logic [2:0] sel_in = 3'd0;
    logic       dir_in = 1'b0;
    logic [7:0] steps = 8'd0;
    logic       pll_rst, phase_dir, phase_step_n, ready, video_rst;
    logic       phase_busy, phase_done, lock_lost, fail;
    logic [2:0] phase_sel;
    logic [3:0] retry_cnt;

    video_pll_ctrl #(.RST_PULSE(RP), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS),
                     .MAX_RETRY(MR), .PHASE_GAP(PG)) dut (
        .clk_i(clk), .rst_i(rst), .pll_lock_i(pll_lock), .start_i(start),
        .phase_req_i(phase_req), .phase_sel_i(sel_in), .phase_dir_i(dir_in),
        .phase_steps_i(steps), .pll_rst_o(pll_rst), .phase_sel_o(phase_sel),
        .phase_dir_o(phase_dir), .phase_step_n_o(phase_step_n), .ready_o(ready),
        .video_rst_o(video_rst), .phase_busy_o(phase_busy), .phase_done_o(phase_done),
        .lock_lost_o(lock_lost), .fail_o(fail), .retry_cnt_o(retry_cnt)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;

    logic [15:0] dut_out;
    assign dut_out = {pll_rst, phase_sel, phase_dir, phase_step_n, ready, video_rst,
                      phase_busy, phase_done, lock_lost, fail, retry_cnt};

    localparam logic [15:0] RST_VEC = {1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1,
                                       1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

    // Behavioural model: mode plus elapsed-cycles-in-mode, unbounded integers.
    typedef enum {M_RST, M_WAIT, M_STAB, M_RUN, M_STEP, M_GAP, M_FAIL} mmode_t;
    mmode_t     mm = M_RST;
    int         m_since = 0, m_retry = 0, m_left = 0;
    logic [2:0] m_sel = 3'd0;
    logic       m_dir = 1'b0, m_done = 1'b0, m_lost = 1'b0, ms1 = 1'b0, ms2 = 1'b0;

    task automatic model_step();
        mmode_t nm;
        logic   live;
        logic   re;
        if (rst) begin
            mm = M_RST; m_since = 0; m_retry = 0; m_left = 0; m_sel = 3'd0;
            m_dir = 1'b0; m_done = 1'b0; m_lost = 1'b0; ms1 = 1'b0; ms2 = 1'b0;
            return;
        end
        nm = mm; re = 1'b0; m_done = 1'b0; m_lost = 1'b0;
        live = (mm == M_RUN) || (mm == M_STEP) || (mm == M_GAP);
        if (start) begin
            nm = M_RST; m_retry = 0; re = 1'b1;
        end else if (live && !ms2) begin
            nm = M_RST; m_lost = 1'b1;
        end else begin
            case (mm)
                M_RST:  if (m_since + 1 == RP) nm = M_WAIT;
                M_WAIT: if (ms2) nm = M_STAB;
                        else if (m_since + 1 == LT) begin
                            m_retry++;
                            nm = (m_retry == MR) ? M_FAIL : M_RST;
                        end
                M_STAB: if (!ms2) nm = M_WAIT;
                        else if (m_since + 1 == LS) begin nm = M_RUN; m_retry = 0; end
                M_RUN:  if (phase_req) begin
                            if (steps == 0) m_done = 1'b1;
                            else begin
                                m_sel = sel_in; m_dir = dir_in; m_left = steps; nm = M_STEP;
                            end
                        end
                M_STEP: begin m_left--; nm = M_GAP; end
                M_GAP:  if (m_since + 1 == PG) begin
                            if (m_left > 0) nm = M_STEP;
                            else begin nm = M_RUN; m_done = 1'b1; end
                        end
                default: nm = mm;
            endcase
        end
        m_since = (re || nm != mm) ? 0 : m_since + 1;
        mm = nm;
        ms2 = ms1; ms1 = pll_lock;
    endtask

    function automatic logic [15:0] model_out();
        logic rdy;
        rdy = (mm == M_RUN) || (mm == M_STEP) || (mm == M_GAP);
        return {(mm == M_RST) || (mm == M_FAIL), m_sel, m_dir, mm != M_STEP, rdy, !rdy,
                (mm == M_STEP) || (mm == M_GAP), m_done, m_lost, mm == M_FAIL, 4'(m_retry)};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    task automatic check_rng(input string name, input int v, input int lo, input int hi);
        n_chk++;
        if (v < lo || v > hi) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d..%0d", name, cyc, v, lo, hi);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check("model_outputs", dut_out, model_out());
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (!ready && k < 200) begin tick(); k++; end
        check(name, 16'(ready), 16'd1);
    endtask

    typedef struct {
        logic       req;
        logic [2:0] sel;
        logic       dir;
        logic [7:0] steps;
        logic [6:0] exp;  // {step_n, busy, done, sel[2:0], dir}
    } vec_t;
    vec_t tbl[17];

    function automatic vec_t mk(input logic r, input logic [2:0] s, input logic d,
                                input logic [7:0] n, input logic sn, input logic b,
                                input logic dn, input logic [2:0] es, input logic ed);
        vec_t v;
        v.req = r; v.sel = s; v.dir = d; v.steps = n; v.exp = {sn, b, dn, es, ed};
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        int k, hi, low_left;
        logic saw_lost, saw_done, saw_rst;
        tbl[0]  = mk(1, 3'd2, 1, 8'd3, 0, 1, 0, 3'd2, 1);
        tbl[1]  = mk(0, 3'd6, 0, 8'd9, 1, 1, 0, 3'd2, 1);
        tbl[2]  = mk(0, 3'd6, 0, 8'd9, 1, 1, 0, 3'd2, 1);
        tbl[3]  = mk(0, 3'd6, 0, 8'd9, 0, 1, 0, 3'd2, 1);
        tbl[4]  = mk(0, 3'd6, 0, 8'd9, 1, 1, 0, 3'd2, 1);
        tbl[5]  = mk(0, 3'd6, 0, 8'd9, 1, 1, 0, 3'd2, 1);
        tbl[6]  = mk(0, 3'd6, 0, 8'd9, 0, 1, 0, 3'd2, 1);
        tbl[7]  = mk(0, 3'd6, 0, 8'd9, 1, 1, 0, 3'd2, 1);
        tbl[8]  = mk(0, 3'd6, 0, 8'd9, 1, 1, 0, 3'd2, 1);
        tbl[9]  = mk(0, 3'd6, 0, 8'd9, 1, 0, 1, 3'd2, 1);
        tbl[10] = mk(0, 3'd6, 0, 8'd9, 1, 0, 0, 3'd2, 1);
        tbl[11] = mk(1, 3'd5, 0, 8'd0, 1, 0, 1, 3'd2, 1);
        tbl[12] = mk(0, 3'd5, 0, 8'd0, 1, 0, 0, 3'd2, 1);
        tbl[13] = mk(1, 3'd7, 0, 8'd1, 0, 1, 0, 3'd7, 0);
        tbl[14] = mk(0, 3'd1, 1, 8'd4, 1, 1, 0, 3'd7, 0);
        tbl[15] = mk(0, 3'd1, 1, 8'd4, 1, 1, 0, 3'd7, 0);
        tbl[16] = mk(0, 3'd1, 1, 8'd4, 1, 0, 1, 3'd7, 0);

        // Reset state
        rst = 1'b1; pll_lock = 1'b1;
        repeat (3) tick();
        check("reset_state", dut_out, RST_VEC);

        // Power-up with lock held high
        rst = 1'b0; k = 0;
        do begin tick(); k++; end while (pll_rst && k < 50);
        check_rng("pll_rst_fall_edge", k, RP, RP);
        while (!ready && k < 100) begin tick(); k++; end
        check_rng("ready_rise_edge", k, RP + 1 + LS, RP + 1 + 2 + LS + 1);
        check("video_rst_fall", 16'(video_rst), 16'd0);
        repeat (3) tick();

        // Phase burst vector table
        for (int i = 0; i < 17; i++) begin
            phase_req = tbl[i].req; sel_in = tbl[i].sel; dir_in = tbl[i].dir; steps = tbl[i].steps;
            tick();
            check($sformatf("burst_row%0d", i),
                  16'({phase_step_n, phase_busy, phase_done, phase_sel, phase_dir}), 16'(tbl[i].exp));
        end
        phase_req = 1'b0;
        repeat (2) tick();

        // Lock drop during the second step
        phase_req = 1'b1; sel_in = 3'd3; dir_in = 1'b0; steps = 8'd3;
        tick();
        phase_req = 1'b0; k = 0;
        do begin tick(); k++; end while (phase_step_n && k < 10);
        pll_lock = 1'b0; saw_lost = 1'b0; saw_done = 1'b0;
        repeat (6) begin
            tick();
            saw_lost |= lock_lost;
            saw_done |= phase_done;
        end
        check("drop_lock_lost", 16'(saw_lost), 16'd1);
        check("drop_no_done", 16'(saw_done), 16'd0);
        check("drop_outputs", 16'({pll_rst, ready, phase_step_n}), 16'b101);
        pll_lock = 1'b1;
        wait_ready("drop_recover");

        // One-cycle lock glitch in the fifth STABLE cycle
        start = 1'b1; tick(); start = 1'b0; k = 0; saw_rst = 1'b0;
        repeat (7) begin tick(); k++; if (k >= RP) saw_rst |= pll_rst; end
        pll_lock = 1'b0; tick(); k++; pll_lock = 1'b1;
        while (!ready && k < 100) begin tick(); k++; saw_rst |= pll_rst; end
        check("glitch_no_pll_rst", 16'(saw_rst), 16'd0);
        check_rng("glitch_ready_edge", k, RP + 1 + 4 + 1 + 1 + LS, RP + 1 + 4 + 1 + 1 + LS);

        // Lock never arrives: retries exhausted
        pll_lock = 1'b0; start = 1'b1; hi = 0; k = 0;
        tick(); start = 1'b0;
        if (pll_rst && !fail) hi++;
        while (!fail && k < 300) begin tick(); k++; if (pll_rst && !fail) hi++; end
        check_rng("fail_pll_rst_cycles", hi, 2 * RP, 2 * RP);
        check("fail_state", 16'({fail, pll_rst, ready, retry_cnt}), 16'({3'b110, 4'(MR)}));
        repeat (5) tick();
        check("fail_sticky", 16'({fail, pll_rst}), 16'b11);
        start = 1'b1; tick(); start = 1'b0;
        check("fail_cleared", 16'({fail, pll_rst, retry_cnt}), 16'({2'b01, 4'd0}));
        pll_lock = 1'b1;
        wait_ready("fail_recover");

        // rst asserted inside a phase gap
        phase_req = 1'b1; sel_in = 3'd1; dir_in = 1'b1; steps = 8'd2;
        tick(); phase_req = 1'b0;
        tick();
        check("in_gap", 16'({phase_busy, phase_step_n}), 16'b11);
        rst = 1'b1; tick();
        check("rst_in_gap", dut_out, RST_VEC);
        rst = 1'b0;
        wait_ready("rst_recover");

        // Random traffic
        low_left = 0;
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 999) == 0);
            start     = ($urandom_range(0, 299) == 0);
            phase_req = ($urandom_range(0, 7) == 0);
            sel_in    = 3'($urandom_range(0, 7));
            dir_in    = 1'($urandom_range(0, 1));
            steps     = 8'($urandom_range(0, 4));
            if (low_left > 0) begin
                pll_lock = 1'b0; low_left--;
            end else begin
                pll_lock = 1'b1;
                if ($urandom_range(0, 199) == 0) low_left = $urandom_range(1, 70);
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
